// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the fetch/memory-stage SRAM arbiter.
//   arb_state_e         : arbiter FSM states
//   req_id_e            : requester identity (fetch or memory stage)
//   DEFAULT_WAIT_CYCLES : default SRAM access length in cycles
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_IF  = 2'd1,
        ACC_MEM = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter timing one SRAM access.
//   clk, rst  : clock, async active-high reset (count -> 0)
//   load      : load load_val (takes priority over dec)
//   load_val  : value loaded at access start
//   dec       : decrement request; saturates at zero
//   zero      : count is zero (final cycle of an access)
module mem_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (dec && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port SRAM between the fetch stage (IF, read
// only) and the memory stage (MEM, read/write). Each access takes
// WAIT_CYCLES cycles and is followed by one IDLE turnaround cycle.
//   clk, rst                       : clock, async active-high reset
//   if_req/if_addr                 : fetch read request and address
//   if_rdata/if_ready              : fetch data and completion strobe
//   mem_req/mem_we/mem_addr/wdata  : memory-stage request
//   mem_rdata/mem_ready            : load data and completion strobe
//   sram_en/we/addr/wdata/rdata    : shared SRAM port
// Optional: define MEM_ARB_RR_EN for round-robin on contention; otherwise
// the memory stage always wins.
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic        cnt_zero;
    logic        start;
    logic        acc;
    logic        final_cyc;
    logic        prio_mem;   // MEM wins when both request

`ifdef MEM_ARB_RR_EN
    req_id_e last_grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant_q <= REQ_IF;
        else if (start)
            last_grant_q <= (state_d == ACC_MEM) ? REQ_MEM : REQ_IF;
    end

    assign prio_mem = (last_grant_q == REQ_IF);
`else
    assign prio_mem = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_req && (!if_req || prio_mem))
                    state_d = ACC_MEM;
                else if (if_req)
                    state_d = ACC_IF;
            end
            ACC_IF, ACC_MEM: begin
                if (cnt_zero)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc       = (state_q != IDLE);
    assign start     = (state_q == IDLE) && (state_d != IDLE);
    assign final_cyc = acc && cnt_zero;

    // Capture the granted request on entry; the requester may change or drop
    // its inputs afterwards without disturbing the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (start) begin
            if (state_d == ACC_MEM) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                we_q    <= mem_we;
            end else begin
                addr_q  <= if_addr;
                wdata_q <= '0;
                we_q    <= 1'b0;
            end
        end
    end

    mem_wait_counter #(.W(4)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (LOAD_VAL),
        .dec      (acc),
        .zero     (cnt_zero)
    );

    assign sram_en    = acc;
    assign sram_we    = (state_q == ACC_MEM) && we_q;
    assign sram_addr  = acc ? addr_q  : '0;
    assign sram_wdata = acc ? wdata_q : '0;

    // Ready is gated by the live request so a flushed access completes
    // silently.
    assign if_ready  = final_cyc && (state_q == ACC_IF)  && if_req;
    assign mem_ready = final_cyc && (state_q == ACC_MEM) && mem_req;
    assign if_rdata  = if_ready  ? sram_rdata : '0;
    assign mem_rdata = mem_ready ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_CYCLES=2 instance for most vectors,
// WAIT_CYCLES=1 instance for back-to-back timing. Cycle k starts at a rising
// edge; inputs change 1 time unit after it and outputs are checked 1 unit
// later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;

    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
    logic        if_ready, mem_ready, sram_en, sram_we;

    logic [31:0] if_rdata1, mem_rdata1, sram_addr1, sram_wdata1;
    logic        if_ready1, mem_ready1, sram_en1, sram_we1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ready(if_ready1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
        .sram_en(sram_en1), .sram_we(sram_we1), .sram_addr(sram_addr1),
        .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance to the start of the next cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold reset across one edge; returns at the start of an IDLE cycle 0
    task automatic do_reset();
        if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        sram_rdata = 32'hE3A01005;
        do_reset();
        rst = 1; #1;
        check("rst_en",    32'(sram_en),   0);
        check("rst_addr",  sram_addr,      0);
        check("rst_ready", 32'({if_ready, mem_ready}), 0);
        rst = 0;

        // IF-only read
        if_req = 1; if_addr = 32'h10; #1;
        check("if_c0_en", 32'(sram_en), 0);
        check("if_c0_rdy", 32'(if_ready), 0);
        tick(); #1;
        check("if_c1_en", 32'(sram_en), 1);
        check("if_c1_addr", sram_addr, 32'h10);
        check("if_c1_we", 32'(sram_we), 0);
        check("if_c1_rdy", 32'(if_ready), 0);
        tick(); #1;
        check("if_c2_rdy", 32'(if_ready), 1);
        check("if_c2_data", if_rdata, 32'hE3A01005);
        check("if_c2_we", 32'(sram_we), 0);
        check("if_c2_mrdy", 32'(mem_ready), 0);
        tick(); if_req = 0; #1;
        check("if_c3_en", 32'(sram_en), 0);
        check("if_c3_data", if_rdata, 0);

        // MEM write
        do_reset();
        mem_req = 1; mem_we = 1; mem_addr = 32'h400; mem_wdata = 32'hDEADBEEF; #1;
        check("wr_c0_we", 32'(sram_we), 0);
        tick(); #1;
        check("wr_c1_we", 32'(sram_we), 1);
        check("wr_c1_addr", sram_addr, 32'h400);
        check("wr_c1_wdata", sram_wdata, 32'hDEADBEEF);
        check("wr_c1_rdy", 32'(mem_ready), 0);
        tick(); #1;
        check("wr_c2_we", 32'(sram_we), 1);
        check("wr_c2_rdy", 32'(mem_ready), 1);
        tick(); mem_req = 0; mem_we = 0; #1;
        check("wr_c3_we", 32'(sram_we), 0);
        check("wr_c3_wdata", sram_wdata, 0);

        // contention, MEM drops after service
        do_reset();
        sram_rdata = 32'h0000_1234;
        if_req = 1; if_addr = 32'h20; mem_req = 1; mem_addr = 32'h200; #1;
        tick(); #1;
        check("ct_c1_addr", sram_addr, 32'h200);
        tick(); #1;
        check("ct_c2_mrdy", 32'(mem_ready), 1);
        check("ct_c2_mdata", mem_rdata, 32'h0000_1234);
        check("ct_c2_irdy", 32'(if_ready), 0);
        tick(); mem_req = 0; #1;
        check("ct_c3_en", 32'(sram_en), 0);
        tick(); #1;
        check("ct_c4_addr", sram_addr, 32'h20);
        tick(); #1;
        check("ct_c5_irdy", 32'(if_ready), 1);
        check("ct_c5_mdata", mem_rdata, 0);
        tick(); if_req = 0; #1;

        // sustained contention: three grants in cycles 1-2, 4-5, 7-8
        do_reset();
        if_req = 1; mem_req = 1; if_addr = 32'h24; mem_addr = 32'h300; #1;
        for (int g = 0; g < 3; g++) begin
            logic exp_mem;
`ifdef MEM_ARB_RR_EN
            exp_mem = (g != 1);
`else
            exp_mem = 1'b1;
`endif
            tick(); tick(); #1;
            check($sformatf("rr_g%0d_mrdy", g), 32'(mem_ready), 32'(exp_mem));
            check($sformatf("rr_g%0d_irdy", g), 32'(if_ready), 32'(!exp_mem));
            tick(); #1;
        end
        if_req = 0; mem_req = 0;

        // IF flush mid-access
        do_reset();
        if_req = 1; if_addr = 32'h30; #1;
        tick(); if_req = 0; #1;
        check("fl_c1_en", 32'(sram_en), 1);
        tick(); #1;
        check("fl_c2_en", 32'(sram_en), 1);
        check("fl_c2_rdy", 32'(if_ready), 0);
        check("fl_c2_data", if_rdata, 0);
        tick(); #1;
        check("fl_c3_en", 32'(sram_en), 0);
        tick(); #1;
        check("fl_c4_en", 32'(sram_en), 0);

        // reset during MEM write
        do_reset();
        mem_req = 1; mem_we = 1; mem_addr = 32'h400; mem_wdata = 32'h12345678; #1;
        tick(); #1;
        check("rm_c1_we_pre", 32'(sram_we), 1);
        rst = 1; #1;
        check("rm_c1_en", 32'(sram_en), 0);
        check("rm_c1_we", 32'(sram_we), 0);
        check("rm_c1_rdy", 32'(mem_ready), 0);
        tick(); rst = 0; #1;
        check("rm_c2_en", 32'(sram_en), 0);
        tick(); #1;
        check("rm_c3_we", 32'(sram_we), 1);
        check("rm_c3_addr", sram_addr, 32'h400);
        tick(); #1;
        check("rm_c4_rdy", 32'(mem_ready), 1);
        tick(); mem_req = 0; mem_we = 0; #1;

        // WAIT_CYCLES=1, IF held: ready on every second cycle
        do_reset();
        sram_rdata = 32'hA5A5_0001;
        if_req = 1; if_addr = 32'h40; #1;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("w1_c%0d_rdy", c), 32'(if_ready1), 32'(c % 2));
            check($sformatf("w1_c%0d_data", c), if_rdata1, (c % 2) ? 32'hA5A5_0001 : 32'h0);
            tick(); #1;
        end
        if_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
